// File: rtl/fighter_state_ctrl.sv
// Fighter movement/attack/stun state controller, advancing once per frame_tick.
// Optional: define DIR_ATTACK_EN to enable directional attacks (states 6..8).
module fighter_state_ctrl #(
  parameter int unsigned IS_MIRRORED = 0,
  parameter int unsigned ATK_START   = 5,
  parameter int unsigned ATK_ACTIVE  = 2,
  parameter int unsigned ATK_REC     = 15,
  parameter int unsigned DIR_START   = 4,
  parameter int unsigned DIR_ACTIVE  = 3,
  parameter int unsigned DIR_REC     = 10,
  parameter int unsigned HITSTUN     = 15,
  parameter int unsigned BLOCKSTUN   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_attack,
  input  logic       got_hit,
  output logic [3:0] state,
  output logic       attack_active,
  output logic       busy,
  output logic       state_changed
);

  localparam int unsigned CW = 5;

`ifdef DIR_ATTACK_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_BACK  = 4'd1,
    ST_FWD   = 4'd2,
    ST_ATK_S = 4'd3,
    ST_ATK_A = 4'd4,
    ST_ATK_R = 4'd5,
    ST_DIR_S = 4'd6,
    ST_DIR_A = 4'd7,
    ST_DIR_R = 4'd8,
    ST_HIT   = 4'd9,
    ST_BLOCK = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hit_pending_q, hit_pending_d;
  logic            atk_prev_q, atk_prev_d;
  logic            fwd, back, hit_now, atk_edge;

  function automatic logic [CW-1:0] load(input int unsigned d);
    return CW'(d - 1);
  endfunction

  assign fwd      = (IS_MIRRORED != 0) ? btn_left : btn_right;
  assign back     = (IS_MIRRORED != 0) ? btn_right : btn_left;
  // A hit arriving on the tick cycle itself is taken at that tick.
  assign hit_now  = hit_pending_q | got_hit;
  assign atk_edge = btn_attack & ~atk_prev_q;

  // Next-state logic; all decisions gated by frame_tick.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hit_pending_d = hit_now;
    atk_prev_d    = atk_prev_q;
    if (frame_tick) begin
      hit_pending_d = 1'b0;
      atk_prev_d    = btn_attack;
      if (hit_now) begin
        if (back && (state_q == ST_IDLE || state_q == ST_BACK || state_q == ST_BLOCK)) begin
          state_d = ST_BLOCK;
          cnt_d   = load(BLOCKSTUN);
        end else begin
          state_d = ST_HIT;
          cnt_d   = load(HITSTUN);
        end
      end else if (state_q >= ST_ATK_S) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          case (state_q)
            ST_ATK_S: begin state_d = ST_ATK_A; cnt_d = load(ATK_ACTIVE); end
            ST_ATK_A: begin state_d = ST_ATK_R; cnt_d = load(ATK_REC);    end
            ST_DIR_S: begin state_d = ST_DIR_A; cnt_d = load(DIR_ACTIVE); end
            ST_DIR_A: begin state_d = ST_DIR_R; cnt_d = load(DIR_REC);    end
            default:  state_d = ST_IDLE;
          endcase
        end
      end else if (atk_edge) begin
        if (DIR_EN && (fwd ^ back)) begin
          state_d = ST_DIR_S;
          cnt_d   = load(DIR_START);
        end else begin
          state_d = ST_ATK_S;
          cnt_d   = load(ATK_START);
        end
      end else if (fwd && !back) begin
        state_d = ST_FWD;
      end else if (back && !fwd) begin
        state_d = ST_BACK;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hit_pending_q <= 1'b0;
      atk_prev_q    <= 1'b0;
      attack_active <= 1'b0;
      busy          <= 1'b0;
      state_changed <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hit_pending_q <= hit_pending_d;
      atk_prev_q    <= atk_prev_d;
      attack_active <= (state_d == ST_ATK_A) || (state_d == ST_DIR_A);
      busy          <= (state_d >= ST_ATK_S);
      state_changed <= (state_d != state_q);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// Scoreboard bench for fighter_state_ctrl: normal and mirrored instances against a tick-level model.
module tb_fighter_state_ctrl;

  logic clk = 1'b0;
  logic rst_n, frame_tick, btn_left, btn_right, btn_attack, got_hit;
  logic [3:0] state0, state1;
  logic aa0, aa1, busy0, busy1, chg0, chg1;

  always #5 clk = ~clk;

  fighter_state_ctrl #(.IS_MIRRORED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .got_hit(got_hit),
    .state(state0), .attack_active(aa0), .busy(busy0), .state_changed(chg0));

  fighter_state_ctrl #(.IS_MIRRORED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
    .btn_right(btn_right), .btn_attack(btn_attack), .got_hit(got_hit),
    .state(state1), .attack_active(aa1), .busy(busy1), .state_changed(chg1));

`ifdef DIR_ATTACK_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  // Ticks spent in each timed state, and where it goes when that time is up.
  localparam int DUR [11]  = '{0, 0, 0, 5, 2, 15, 4, 3, 10, 15, 10};
  localparam int SUCC [11] = '{0, 0, 0, 4, 5, 0, 7, 8, 0, 0, 0};

  typedef struct {
    logic [6:0] e0;
    logic [6:0] e1;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_no = 0;

  int m_st [2];
  int m_left [2];
  bit m_chg [2];
  bit m_pend, m_prev;

  function automatic logic [6:0] pack(input int i);
    return {4'(m_st[i]), (m_st[i] == 4 || m_st[i] == 7), (m_st[i] >= 3), m_chg[i]};
  endfunction

  task automatic check(input string name, input int c, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got st=%0d aa=%b busy=%b chg=%b, want st=%0d aa=%b busy=%b chg=%b",
               name, c, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic enter(input int i, input int s);
    m_st[i]   = s;
    m_left[i] = DUR[s];
  endtask

  // One clock of the reference: reacts only at ticks, timed states count remaining ticks.
  task automatic model(input bit rst, input bit tick, input bit l, input bit r, input bit a, input bit h);
    bit hit, atk_edge, fwd, bk;
    int old;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_left[i] = 0; m_chg[i] = 1'b0;
      end
      m_pend = 1'b0;
      m_prev = 1'b0;
      return;
    end
    if (!tick) begin
      m_pend = m_pend | h;
      m_chg[0] = 1'b0;
      m_chg[1] = 1'b0;
      return;
    end
    hit      = m_pend | h;
    atk_edge = a && !m_prev;
    m_pend   = 1'b0;
    m_prev   = a;
    for (int i = 0; i < 2; i++) begin
      fwd = (i == 1) ? l : r;
      bk  = (i == 1) ? r : l;
      old = m_st[i];
      if (hit) begin
        if (bk && (old == 0 || old == 1 || old == 10)) enter(i, 10);
        else enter(i, 9);
      end else if (old >= 3) begin
        if (m_left[i] == 1) begin
          if (SUCC[old] == 0) begin m_st[i] = 0; m_left[i] = 0; end
          else enter(i, SUCC[old]);
        end else begin
          m_left[i]--;
        end
      end else if (atk_edge) begin
        if (DIR_EN && (fwd != bk)) enter(i, 6);
        else enter(i, 3);
      end else begin
        m_st[i] = (fwd && !bk) ? 2 : (bk && !fwd) ? 1 : 0;
      end
      m_chg[i] = (m_st[i] != old);
    end
  endtask

  task automatic cyc(input bit rst, input bit tick, input bit l, input bit r, input bit a, input bit h);
    exp_t e;
    @(negedge clk);
    rst_n = rst; frame_tick = tick; btn_left = l; btn_right = r; btn_attack = a; got_hit = h;
    model(rst, tick, l, r, a, h);
    cyc_no++;
    e.e0 = pack(0); e.e1 = pack(1); e.cyc = cyc_no;
    q.push_back(e);
    if (!rst) begin
      #1;
      check("async_reset_dut0", cyc_no, {state0, aa0, busy0, chg0}, 7'd0);
      check("async_reset_dut1", cyc_no, {state1, aa1, busy1, chg1}, 7'd0);
    end
  endtask

  task automatic tk(input bit l, input bit r, input bit a, input bit h);
    cyc(1'b1, 1'b0, l, r, a, h);
    cyc(1'b1, 1'b1, l, r, a, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, compared after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dut0_outputs", e.cyc, {state0, aa0, busy0, chg0}, e.e0);
        check("dut1_mirrored_outputs", e.cyc, {state1, aa1, busy1, chg1}, e.e1);
      end
    end
  end

  initial begin
    bit l, r, a, h, t, rs;
    rst_n = 1'b0; frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_attack = 1'b0; got_hit = 1'b0;
    m_st = '{0, 0}; m_left = '{0, 0}; m_chg = '{1'b0, 1'b0};
    m_pend = 1'b0; m_prev = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Right held for three ticks.
    repeat (3) tk(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Neutral attack held through its full duration.
    repeat (25) tk(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Forward held plus attack edge.
    tk(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) tk(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Hit during attack active.
    repeat (6) tk(1'b0, 1'b0, 1'b1, 1'b0);
    tk(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (17) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Hit while walking backward with back held.
    repeat (2) tk(1'b1, 1'b0, 1'b0, 1'b0);
    tk(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (12) tk(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Double hit between ticks, then a reload at hitstun tick 8.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (7) tk(1'b0, 1'b0, 1'b0, 1'b0);
    tk(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (17) tk(1'b0, 1'b0, 1'b0, 1'b0);
    // Reset in attack recovery with attack held through release.
    repeat (10) tk(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tk(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized play.
    l = 1'b0; r = 1'b0; a = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(7) == 0) l = ~l;
      if ($urandom_range(7) == 0) r = ~r;
      if ($urandom_range(4) == 0) a = ~a;
      h  = ($urandom_range(79) == 0);
      t  = ($urandom_range(2) == 0);
      rs = ($urandom_range(1499) != 0);
      cyc(rs, t, l, r, a, h);
    end

    repeat (4) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
